regfile_dump_sequencer: RTL and testbench

//  Debug-side controller that borrows one register-file read port while the CPU pipeline is halted.
//  It walks registers FIRST_REG..LAST_REG and streams each word as bytes over a valid/ready

---
 rtl/regfile_dump_sequencer_pkg.sv | 30 +++
 rtl/regfile_dump_sequencer_serializer.sv | 94 +++++++++
 rtl/regfile_dump_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_regfile_dump_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_sequencer_pkg
// Shared definitions for the register-file dump sequencer:
//   - state_t        : FSM state encodings (IDLE, LOAD, SEND, NEXT, CSUM, DONE)
//   - BYTE_W         : width of one streamed byte
//   - bytes_per_word : number of bytes in a register word (DATA_W / 8)
//   - count_width    : width of a counter able to index n items (min 1 bit)
// -----------------------------------------------------------------------------
package regfile_dump_sequencer_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_NEXT = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return data_w / BYTE_W;
   endfunction

   function automatic int unsigned count_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_dump_sequencer_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Holds one captured register word and presents it byte by byte on a
// valid/ready interface. Once tx_valid is raised, tx_valid and tx_data hold
// until the byte is accepted.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   capture      : load word into the shift register, clear byte counter
//   word         : register word to serialise
//   send_en      : present the next byte of the captured word when idle
//   more         : after the current transfer, continue with the next byte
//                  (ignored on the last byte)
//   inject_en    : present inject_byte when idle (used for the checksum byte)
//   inject_byte  : extra byte to present
//   tx_ready     : downstream accepts the byte
//   tx_data      : byte presented downstream
//   tx_valid     : tx_data valid
//   xfer         : tx_valid & tx_ready this cycle
//   last_byte    : the byte currently presented is the last of the word
// -----------------------------------------------------------------------------
module word_byte_serializer
   import regfile_dump_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic [DATA_W-1:0] word,
   input  logic              send_en,
   input  logic              more,
   input  logic              inject_en,
   input  logic [7:0]        inject_byte,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              xfer,
   output logic              last_byte
);

   localparam int unsigned BPW   = bytes_per_word(DATA_W);
   localparam int unsigned CNT_W = count_width(BPW);

   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_next;
   logic [CNT_W-1:0]  cnt_q;
   logic [7:0]        head_byte;

   // The byte about to be presented always sits at one fixed end of the
   // shift register; consuming it shifts the word toward that end.
   assign head_byte  = MSB_FIRST ? shift_q[DATA_W-1 -: 8] : shift_q[7:0];
   assign shift_next = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);

   assign xfer      = tx_valid & tx_ready;
   assign last_byte = (cnt_q == CNT_W'(BPW - 1));

   // NOTE: every register here is assigned with <= so all updates in this
   // block see the pre-edge values of shift_q, cnt_q and tx_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         cnt_q    <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
      end else begin
         if (capture) begin
            shift_q <= word;
            cnt_q   <= '0;
         end
         if (tx_valid) begin
            // Holding: nothing changes until the byte is accepted.
            if (tx_ready) begin
               cnt_q <= cnt_q + 1'b1;
               if (more && !last_byte) begin
                  tx_data <= head_byte;
                  shift_q <= shift_next;
               end else begin
                  tx_valid <= 1'b0;
               end
            end
         end else if (send_en) begin
            tx_valid <= 1'b1;
            tx_data  <= head_byte;
            shift_q  <= shift_next;
         end else if (inject_en) begin
            tx_valid <= 1'b1;
            tx_data  <= inject_byte;
         end
      end
   end

endmodule

// File: rtl/regfile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_dump_sequencer
// Debug-side controller that borrows one register-file read port while the
// CPU pipeline is halted, walks registers FIRST_REG..LAST_REG and streams each
// word as bytes toward the debug UART transmitter.
//
// Optional feature: define REGDUMP_CHECKSUM_EN to append one byte holding the
// XOR of all bytes sent in a completed (non-aborted) dump.
//
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   start         : dump request pulse from the debug unit
//   halted        : pipeline halted, register file not being written
//   rf_sel        : read-port mux selects rf_read_addr (high whenever busy)
//   rf_read_addr  : register index for the read port
//   rf_read_data  : combinational read data for rf_read_addr
//   tx_data       : byte to UART TX
//   tx_valid      : tx_data valid
//   tx_ready      : UART TX accepts the byte
//   busy          : dump in progress
//   done          : one-cycle pulse when a dump ends
//   aborted       : valid with done; halted dropped mid-dump
// -----------------------------------------------------------------------------
module regfile_dump_sequencer
   import regfile_dump_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halted,
   output logic              rf_sel,
   output logic [ADDR_W-1:0] rf_read_addr,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              pending_q, pending_d;
   logic              abort_req_q, abort_req_d;
   logic              aborted_q, aborted_d;

   logic              capture;
   logic              send_en;
   logic              more;
   logic              inject_en;
   logic [7:0]        inject_byte;
   logic              xfer;
   logic              last_byte;

   // NOTE: every signal written here gets its default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pending_d   = pending_q;
      abort_req_d = abort_req_q;
      aborted_d   = aborted_q;
      capture     = 1'b0;

      // A request arriving in DONE is kept too: the block is back in IDLE
      // on the very next edge.
      if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if ((start || pending_q) && halted) begin
               state_d     = ST_LOAD;
               idx_d       = ADDR_W'(FIRST_REG);
               pending_d   = 1'b0;
               abort_req_d = 1'b0;
               aborted_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (!halted) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else begin
               capture = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_valid) begin
               // No byte in flight yet, so an abort can take effect at once.
               if (!halted) begin
                  state_d   = ST_DONE;
                  aborted_d = 1'b1;
               end
            end else if (xfer) begin
               if (abort_req_q || !halted) begin
                  state_d   = ST_DONE;
                  aborted_d = 1'b1;
               end else if (last_byte) begin
                  state_d = ST_NEXT;
               end
            end else if (!halted) begin
               // Stalled byte must still complete; remember the abort.
               abort_req_d = 1'b1;
            end
         end
         ST_NEXT: begin
            if (!halted) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (idx_q == ADDR_W'(LAST_REG)) begin
`ifdef REGDUMP_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end else begin
               // Compare before increment: idx never wraps past LAST_REG.
               idx_d   = idx_q + 1'b1;
               state_d = ST_LOAD;
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         ST_CSUM: begin
            // All data bytes are out; the checksum byte always completes.
            if (xfer) begin
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= ADDR_W'(FIRST_REG);
         pending_q   <= 1'b0;
         abort_req_q <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         abort_req_q <= abort_req_d;
         aborted_q   <= aborted_d;
      end
   end

   assign send_en = (state_q == ST_SEND) && halted;
   assign more    = send_en && !abort_req_q;

`ifdef REGDUMP_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         csum_q <= '0;
      end else if (state_q == ST_IDLE && state_d == ST_LOAD) begin
         csum_q <= '0;
      end else if (state_q == ST_SEND && xfer) begin
         csum_q <= csum_q ^ tx_data;
      end
   end

   assign inject_en   = (state_q == ST_CSUM);
   assign inject_byte = csum_q;
`else
   assign inject_en   = 1'b0;
   assign inject_byte = '0;
`endif

   word_byte_serializer #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_serializer (
      .clk         (clk),
      .reset       (reset),
      .capture     (capture),
      .word        (rf_read_data),
      .send_en     (send_en),
      .more        (more),
      .inject_en   (inject_en),
      .inject_byte (inject_byte),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .xfer        (xfer),
      .last_byte   (last_byte)
   );

   assign busy         = (state_q != ST_IDLE);
   assign rf_sel       = busy;
   assign rf_read_addr = idx_q;
   assign done         = (state_q == ST_DONE);
   assign aborted      = aborted_q && (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_sequencer
// Two instances share one register-file model: u_full dumps r0..r31, u_one
// dumps r1 only. Expected bytes (with the register index that must be on
// rf_read_addr while each byte goes out) are queued when a dump is started
// and popped as the DUT hands bytes over. Outputs are sampled and inputs
// driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_dump_sequencer;

   typedef struct packed {
      logic [7:0] data;
      logic [4:0] addr;
   } exp_t;

   localparam int RM_ALWAYS = 0;
   localparam int RM_RANDOM = 1;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int CSUM_BYTES = 1;
`else
   localparam int CSUM_BYTES = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        halted;
   logic        tx_ready;
   logic [1:0]  start;
   logic [1:0]  rf_sel;
   logic [1:0]  tx_valid;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [1:0]  aborted;
   logic [4:0]  rf_addr [2];
   logic [31:0] rf_data [2];
   logic [7:0]  tx_data [2];

   logic [31:0] rf_mem [32];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   ready_mode = RM_ALWAYS;
   int   xfers [2];
   bit   stall_v [2];
   logic [7:0] stall_data [2];
   bit   done_seen [2];
   bit   aborted_seen [2];
   exp_t sb0 [$];
   exp_t sb1 [$];

   always #5 clk = ~clk;

   // Register file: index 0 reads as zero.
   assign rf_data[0] = (rf_addr[0] == 5'd0) ? 32'h0 : rf_mem[rf_addr[0]];
   assign rf_data[1] = (rf_addr[1] == 5'd0) ? 32'h0 : rf_mem[rf_addr[1]];

   regfile_dump_sequencer u_full (
      .clk          (clk),
      .reset        (reset),
      .start        (start[0]),
      .halted       (halted),
      .rf_sel       (rf_sel[0]),
      .rf_read_addr (rf_addr[0]),
      .rf_read_data (rf_data[0]),
      .tx_data      (tx_data[0]),
      .tx_valid     (tx_valid[0]),
      .tx_ready     (tx_ready),
      .busy         (busy[0]),
      .done         (done[0]),
      .aborted      (aborted[0])
   );

   regfile_dump_sequencer #(
      .FIRST_REG (1),
      .LAST_REG  (1)
   ) u_one (
      .clk          (clk),
      .reset        (reset),
      .start        (start[1]),
      .halted       (halted),
      .rf_sel       (rf_sel[1]),
      .rf_read_addr (rf_addr[1]),
      .rf_read_data (rf_data[1]),
      .tx_data      (tx_data[1]),
      .tx_valid     (tx_valid[1]),
      .tx_ready     (tx_ready),
      .busy         (busy[1]),
      .done         (done[1]),
      .aborted      (aborted[1])
   );

   function automatic int sb_size(input int d);
      return (d == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic sb_push(input int d, input exp_t e);
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic sb_pop(input int d, output exp_t e);
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
   endtask

   // Queue the bytes of a dump of registers first..last, MSB first. limit < 0
   // means a complete dump (checksum included when enabled); otherwise only
   // the first 'limit' bytes are expected.
   task automatic push_dump(input int d, input int first, input int last, input int limit);
      logic [31:0] w;
      logic [7:0]  cs;
      logic [7:0]  b;
      int          n;
      cs = 8'h00;
      n  = 0;
      for (int r = first; r <= last; r++) begin
         w = (r == 0) ? 32'h0 : rf_mem[r];
         for (int k = 0; k < 4; k++) begin
            b  = w[31-8*k -: 8];
            cs = cs ^ b;
            if (limit < 0 || n < limit) sb_push(d, '{data: b, addr: 5'(r)});
            n++;
         end
      end
      if (limit < 0 && CSUM_BYTES == 1) sb_push(d, '{data: cs, addr: 5'(last)});
   endtask

   // One clock: choose tx_ready for the coming edge, then check whatever
   // that edge will transfer, hold behaviour while stalled, and rf_sel.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (ready_mode == RM_RANDOM) tx_ready = 1'($urandom_range(0, 1));
      else                         tx_ready = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (stall_v[d]) begin
            n_checks++;
            if (tx_valid[d] !== 1'b1 || tx_data[d] !== stall_data[d]) begin
               n_fail++;
               $display("FAIL hold_dut%0d: valid=%b data=%h, required valid=1 data=%h",
                        d, tx_valid[d], tx_data[d], stall_data[d]);
            end
         end
         if (tx_valid[d] === 1'b1 && tx_ready && !reset) begin
            xfers[d]++;
            n_checks++;
            if (sb_size(d) == 0) begin
               n_fail++;
               $display("FAIL byte_dut%0d: unexpected byte %h at addr %0d", d, tx_data[d], rf_addr[d]);
            end else begin
               sb_pop(d, e);
               if (tx_data[d] !== e.data || rf_addr[d] !== e.addr) begin
                  n_fail++;
                  $display("FAIL byte_dut%0d: got %h@%0d, expected %h@%0d",
                           d, tx_data[d], rf_addr[d], e.data, e.addr);
               end
            end
         end
         stall_v[d]    = (tx_valid[d] === 1'b1) && !tx_ready && !reset;
         stall_data[d] = tx_data[d];
         n_checks++;
         if (rf_sel[d] !== busy[d]) begin
            n_fail++;
            $display("FAIL rf_sel_dut%0d: rf_sel=%b, expected busy=%b", d, rf_sel[d], busy[d]);
         end
         if (done[d] === 1'b1) begin
            done_seen[d]    = 1'b1;
            aborted_seen[d] = aborted[d];
         end
      end
   endtask

   task automatic pulse_start(input int d);
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget, input string name);
      int k;
      k = 0;
      done_seen[d] = 1'b0;
      while (!done_seen[d] && k < budget) begin
         tick();
         k++;
      end
      n_checks++;
      if (!done_seen[d]) begin
         n_fail++;
         $display("FAIL %s_done: no done within %0d cycles, expected done=1", name, budget);
      end
   endtask

   task automatic expect_bit(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   task automatic expect_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [4:0] exp_addr [2];
      exp_addr[0] = 5'd0;
      exp_addr[1] = 5'd1;
      reset = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         expect_bit("reset_rf_sel", rf_sel[d], 1'b0);
         expect_bit("reset_tx_valid", tx_valid[d], 1'b0);
         expect_bit("reset_busy", busy[d], 1'b0);
         expect_bit("reset_done", done[d], 1'b0);
         expect_bit("reset_aborted", aborted[d], 1'b0);
         expect_int("reset_tx_data", int'(tx_data[d]), 0);
         expect_int("reset_rf_addr", int'(rf_addr[d]), int'(exp_addr[d]));
      end
      reset = 1'b0;
      tick();
   endtask

   // r1 only: checks start-to-valid latency and the 4-byte stream.
   task automatic test_single_reg();
      int x0;
      x0 = xfers[1];
      halted = 1'b1;
      push_dump(1, 1, 1, -1);
      pulse_start(1);                       // edge N sampled start
      expect_bit("single_busy_n", busy[1], 1'b1);
      expect_bit("single_valid_n", tx_valid[1], 1'b0);
      tick();                               // after N+1
      expect_bit("single_valid_n1", tx_valid[1], 1'b0);
      tick();                               // after N+2
      expect_bit("single_valid_n2", tx_valid[1], 1'b1);
      expect_int("single_first_byte", int'(tx_data[1]), 'h11);
      wait_done(1, 50, "single");
      expect_bit("single_aborted", aborted_seen[1], 1'b0);
      expect_int("single_bytes", xfers[1] - x0, 4 + CSUM_BYTES);
      expect_int("single_sb_left", sb_size(1), 0);
      tick();
      expect_bit("single_busy_after", busy[1], 1'b0);
   endtask

   task automatic test_full_dump(input int mode, input string name);
      int x0;
      ready_mode = mode;
      halted = 1'b1;
      x0 = xfers[0];
      push_dump(0, 0, 31, -1);
      pulse_start(0);
      wait_done(0, 4000, name);
      expect_bit({name, "_aborted"}, aborted_seen[0], 1'b0);
      expect_int({name, "_bytes"}, xfers[0] - x0, 128 + CSUM_BYTES);
      expect_int({name, "_sb_left"}, sb_size(0), 0);
      ready_mode = RM_ALWAYS;
      tick();
   endtask

   // Drop halted while r5 byte 2 (byte 22 of the dump) is being accepted.
   task automatic test_abort();
      int x0;
      int k;
      halted = 1'b1;
      x0 = xfers[0];
      push_dump(0, 0, 31, 23);
      pulse_start(0);
      k = 0;
      while (xfers[0] - x0 < 23 && k < 1000) begin
         tick();
         k++;
      end
      expect_int("abort_reach_r5", xfers[0] - x0, 23);
      halted = 1'b0;
      tick();
      expect_bit("abort_done", done[0], 1'b1);
      expect_bit("abort_aborted", aborted[0], 1'b1);
      tick();
      expect_bit("abort_busy_after", busy[0], 1'b0);
      halted = 1'b1;
      repeat (10) tick();
      expect_int("abort_bytes", xfers[0] - x0, 23);
      expect_int("abort_sb_left", sb_size(0), 0);
      expect_bit("abort_stays_idle", busy[0], 1'b0);
   endtask

   // start while not halted is remembered; start while busy is dropped.
   task automatic test_pending_start();
      bit extra;
      halted = 1'b0;
      pulse_start(0);
      repeat (10) tick();
      expect_bit("pending_wait_idle", busy[0], 1'b0);
      push_dump(0, 0, 31, -1);
      halted = 1'b1;
      tick();
      expect_bit("pending_begins", busy[0], 1'b1);
      repeat (20) tick();
      pulse_start(0);                       // while busy: ignored
      wait_done(0, 4000, "pending");
      extra = 1'b0;
      repeat (30) begin
         tick();
         if (busy[0] === 1'b1) extra = 1'b1;
      end
      expect_bit("busy_start_ignored", extra, 1'b0);
      expect_int("pending_sb_left", sb_size(0), 0);
   endtask

   // start in the same cycle as done starts a second dump after one IDLE cycle.
   task automatic test_back_to_back();
      halted = 1'b1;
      push_dump(1, 1, 1, -1);
      push_dump(1, 1, 1, -1);
      pulse_start(1);
      wait_done(1, 50, "b2b_first");
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      expect_bit("b2b_idle_gap", busy[1], 1'b0);
      tick();
      expect_bit("b2b_restart", busy[1], 1'b1);
      wait_done(1, 50, "b2b_second");
      expect_bit("b2b_aborted", aborted_seen[1], 1'b0);
      expect_int("b2b_sb_left", sb_size(1), 0);
      tick();
   endtask

   task automatic test_reset_mid_dump();
      int x0;
      int k;
      halted = 1'b1;
      x0 = xfers[0];
      push_dump(0, 0, 31, -1);
      pulse_start(0);
      k = 0;
      while (xfers[0] - x0 < 6 && k < 200) begin
         tick();
         k++;
      end
      expect_bit("rst_mid_valid_before", tx_valid[0], 1'b1);
      reset = 1'b1;
      stall_v[0] = 1'b0;
      tick();
      expect_bit("rst_mid_valid", tx_valid[0], 1'b0);
      expect_bit("rst_mid_busy", busy[0], 1'b0);
      expect_int("rst_mid_addr", int'(rf_addr[0]), 0);
      sb0.delete();
      reset = 1'b0;
      repeat (5) tick();
      expect_bit("rst_mid_stays_idle", busy[0], 1'b0);
   endtask

   initial begin
      reset    = 1'b1;
      halted   = 1'b0;
      tx_ready = 1'b1;
      start    = 2'b00;
      for (int d = 0; d < 2; d++) begin
         xfers[d]        = 0;
         stall_v[d]      = 1'b0;
         stall_data[d]   = 8'h00;
         done_seen[d]    = 1'b0;
         aborted_seen[d] = 1'b0;
      end
      for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
      rf_mem[0] = 32'hDEADBEEF;             // must never reach the stream
      rf_mem[1] = 32'h11223344;
      rf_mem[5] = 32'hA1B2C3D4;

      test_reset();
      test_single_reg();
      test_full_dump(RM_ALWAYS, "full");
      test_full_dump(RM_RANDOM, "stall");
      test_abort();
      test_pending_start();
      test_back_to_back();
      test_reset_mid_dump();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
